// File: rtl/counter_pulse_multi.sv
// Windowed multi-channel pulse counter: counts pulses per channel over WINDOW
// cycles (down from MAX_VALUE or up from 0) and hands results off via valid/ready.
module counter_pulse_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_VALUE    = 8,
    parameter int WINDOW       = 16,
    localparam int CW          = $clog2(MAX_VALUE + 1),
    localparam int WCW         = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [NUM_CHANNELS-1:0]    incoming_lines,
    output logic [NUM_CHANNELS*CW-1:0] outgoing_lines,
    output logic                       outgoing_valid,
    input  logic                       outgoing_ready,
    output logic [NUM_CHANNELS-1:0]    saturated,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0]  MAX_C    = CW'(MAX_VALUE);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

    state_t                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [WCW-1:0]             win_q, win_d;
    logic [NUM_CHANNELS*CW-1:0] cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]    sat_q, sat_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;

    // Starting value of every channel for a window in the given mode.
    function automatic logic [NUM_CHANNELS*CW-1:0] load_counts(input logic m);
        logic [NUM_CHANNELS*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (m) begin
                v[i*CW +: CW] = {CW{1'b0}};
            end else begin
                v[i*CW +: CW] = MAX_C;
            end
        end
        return v;
    endfunction

    // Next-state logic: window sequencing, saturating per-channel accumulation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    cnt_d   = load_counts(mode);
                    sat_d   = {NUM_CHANNELS{1'b0}};
                    win_d   = {WCW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (!incoming_lines[i]) begin
                        cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW];
                    end else if (mode_q) begin
                        if (cnt_q[i*CW +: CW] < MAX_C) begin
                            cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CW'(1);
                        end else begin
                            sat_d[i] = 1'b1;
                        end
                    end else begin
                        if (cnt_q[i*CW +: CW] != {CW{1'b0}}) begin
                            cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] - CW'(1);
                        end else begin
                            sat_d[i] = 1'b1;
                        end
                    end
                end
                if (win_q == WIN_LAST) begin
                    state_d = DONE;
                    win_d   = {WCW{1'b0}};
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    win_d   = win_q + WCW'(1);
                end
            end
            DONE: begin
                if (!outgoing_ready) begin
                    state_d = DONE;
                end else if (start) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    cnt_d   = load_counts(mode);
                    sat_d   = {NUM_CHANNELS{1'b0}};
                    win_d   = {WCW{1'b0}};
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a partial window is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            win_q   <= {WCW{1'b0}};
            cnt_q   <= {NUM_CHANNELS{MAX_C}};
            sat_q   <= {NUM_CHANNELS{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign outgoing_lines = cnt_q;
    assign saturated      = sat_q;
    assign outgoing_valid = valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_counter_pulse_multi.sv
// Randomized scoreboard bench for counter_pulse_multi: expected results are
// queued when a window starts and popped by a monitor when valid rises.
module tb_counter_pulse_multi;

    localparam int N   = 4;
    localparam int MAX = 8;
    localparam int W   = 16;
    localparam int CW  = $clog2(MAX + 1);

    typedef struct packed {
        logic [N*CW-1:0] cnt;
        logic [N-1:0]    sat;
    } res_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            mode  = 1'b0;
    logic [N-1:0]    incoming_lines = '0;
    logic [N*CW-1:0] outgoing_lines;
    logic            outgoing_valid;
    logic            outgoing_ready = 1'b0;
    logic [N-1:0]    saturated;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    res_t         exp_q[$];
    res_t         exp_last;
    logic [N-1:0] pat [W];
    logic [N*CW-1:0] rst_cnt;

    counter_pulse_multi #(.NUM_CHANNELS(N), .MAX_VALUE(MAX), .WINDOW(W)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .incoming_lines(incoming_lines), .outgoing_lines(outgoing_lines),
        .outgoing_valid(outgoing_valid), .outgoing_ready(outgoing_ready),
        .saturated(saturated), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the result depends only on the number of high samples per channel.
    function automatic res_t model(input logic m);
        res_t r;
        int   p;
        r = '0;
        for (int i = 0; i < N; i++) begin
            p = 0;
            for (int k = 0; k < W; k++) p += int'(pat[k][i]);
            if (m) r.cnt[i*CW +: CW] = CW'((p > MAX) ? MAX : p);
            else   r.cnt[i*CW +: CW] = CW'((p > MAX) ? 0 : MAX - p);
            r.sat[i] = (p > MAX);
        end
        return r;
    endfunction

    // Start a window (from IDLE, or from DONE when b2b) and drive its W samples.
    task automatic run_window(input logic m, input bit b2b);
        res_t e;
        e = model(m);
        exp_q.push_back(e);
        exp_last = e;
        start = 1'b1;
        mode  = m;
        outgoing_ready = b2b;
        @(posedge clock); #1;
        start = 1'b0;
        outgoing_ready = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(outgoing_valid), 32'd0);
        chk("start_counts", 32'(outgoing_lines), m ? 32'd0 : 32'(rst_cnt));
        chk("start_sat", 32'(saturated), 32'd0);
        for (int k = 0; k < W; k++) begin
            incoming_lines = pat[k];
            mode  = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        start = 1'b0;
        incoming_lines = N'($urandom);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(outgoing_valid), 32'd1);
    endtask

    // Backpressure for 'hold' cycles with stray starts, then accept.
    task automatic release_result(input int hold);
        for (int c = 0; c < hold; c++) begin
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            incoming_lines = N'($urandom);
            @(posedge clock); #1;
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_valid", 32'(outgoing_valid), 32'd1);
        end
        start = 1'b0;
        outgoing_ready = 1'b1;
        @(posedge clock); #1;
        outgoing_ready = 1'b0;
        chk("idle_valid", 32'(outgoing_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold_counts", 32'(outgoing_lines), 32'(exp_last.cnt));
        chk("idle_hold_sat", 32'(saturated), 32'(exp_last.sat));
    endtask

    task automatic random_pat();
        int dens;
        dens = $urandom_range(0, 100);
        for (int k = 0; k < W; k++)
            for (int i = 0; i < N; i++)
                pat[k][i] = ($urandom_range(0, 99) < dens);
    endtask

    // Monitor: pop one expectation per valid rise, check it stays frozen while valid.
    initial begin
        res_t cur;
        bit   have;
        logic valid_prev;
        have = 1'b0;
        valid_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && outgoing_valid) begin
                if (!valid_prev) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_result: got 0x%0h, expected no result", outgoing_lines);
                        have = 1'b0;
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    chk("result_counts", 32'(outgoing_lines), 32'(cur.cnt));
                    chk("result_sat", 32'(saturated), 32'(cur.sat));
                end
            end
            valid_prev = outgoing_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) rst_cnt[i*CW +: CW] = CW'(MAX);

        // Reset dominates start and active lines.
        reset = 1'b0; start = 1'b1; incoming_lines = '1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 32'(outgoing_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(saturated), 32'd0);
        chk("rst_counts", 32'(outgoing_lines), 32'(rst_cnt));
        reset = 1'b1; start = 1'b0; incoming_lines = '0;
        @(posedge clock); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(outgoing_valid), 32'd0);

        // Directed down-mode window.
        for (int k = 0; k < W; k++) pat[k] = {1'(k < 8), 1'b1, 1'b0, 1'(k < 3)};
        run_window(1'b0, 1'b0);
        release_result(5);

        // Directed up-mode window, then back-to-back into a random window.
        for (int k = 0; k < W; k++) pat[k] = {1'b0, 1'(k % 2 == 0), 1'(k == 0), 1'b1};
        run_window(1'b1, 1'b0);
        random_pat();
        run_window(1'b1, 1'b1);
        release_result(2);

        // Mid-window reset: six samples in, reset on the seventh.
        start = 1'b1; mode = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        incoming_lines = '1;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        incoming_lines = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(outgoing_valid), 32'd0);
        chk("midrst_counts", 32'(outgoing_lines), 32'(rst_cnt));
        chk("midrst_sat", 32'(saturated), 32'd0);
        random_pat();
        run_window(1'b0, 1'b0);
        release_result(0);

        // Random windows, mixing back-to-back and released hand-offs.
        for (int r = 0; r < 8; r++) begin
            random_pat();
            run_window(1'($urandom_range(0, 1)), 1'b0);
            random_pat();
            run_window(1'($urandom_range(0, 1)), 1'b1);
            release_result($urandom_range(0, 4));
        end

        @(posedge clock); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
